priv_trap_ctrl: RTL and testbench
=================================

# priv_trap_ctrl

Trap sequencer on the privilege side of the pipeline/priv boundary. It consumes the per-instruction exception flags, `ret`, `epc`, `badaddr` and `pipe_clear` driven by the hazard unit, plus the machine interrupt lines. It picks the highest-priority trap, waits for the pipeline to drain, and produces the `priv_pc`/`insert_pc`/`intr` redirect back to the hazard unit along with the one-cycle CSR update strobes (mcause/mepc/mtval/mstatus) for the machine-mode CSR file.

## Interface
Parameters:
- `NUM_EXT`, default `NUM_EXTENSIONS`: RISC-MGMT extension count; sets the width of `ex_rmgmt_cause`.
- `RMGMT_CAUSE_BASE`, default 24: mcause code for RISC-MGMT exception 0.

Ports:
- `CLK`  in  1  clock; single clock domain.
- `RST`  in  1  reset, asynchronous, active-high.
- `fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env, ret`  in  1 each  hazard-unit event flags.
- `ex_rmgmt`  in  1  RISC-MGMT exception.
- `ex_rmgmt_cause`  in  $clog2(NUM_EXT)  RISC-MGMT index.
- `epc`, `badaddr`  in  32  faulting/interrupted PC and trap value.
- `pipe_clear`  in  1  pipeline drained.
- `timer_int, soft_int, ext_int`  in  1 each  interrupt lines, level.
- `mie_bits`  in  3  {meie, msie, mtie}.
- `mstatus_mie`  in  1  global interrupt enable.
- `mtvec`, `mepc_r`  in  32  current CSR values.
- `priv_pc`  out  32  redirect target.
- `insert_pc`  out  1  redirect strobe.
- `intr`  out  1  interrupt pending; asks the hazard unit to drain.
- `mcause_wen, mepc_wen, mtval_wen`  out  1 each  CSR write strobes.
- `mcause_val, mepc_val, mtval_val`  out  32  CSR write data.
- `mstatus_push`  out  1  MPIE<=MIE, MIE<=0.
- `mstatus_pop`  out  1  MIE<=MPIE, MPIE<=1.

## Operation
- States: IDLE, WAIT_CLEAR, REDIRECT.
- Exception priority, highest first (cause code in parentheses): fault_insn(1), mal_insn(0), illegal_insn(2), breakpoint(3), env(11), mal_s(6), mal_l(4), fault_s(7), fault_l(5), ex_rmgmt(RMGMT_CAUSE_BASE+ex_rmgmt_cause).
- Interrupt qualification: each line ANDed with its `mie_bits` bit and with `mstatus_mie`.
- Interrupt priority: ext(11) > soft(3) > timer(7). mcause bit 31 = 1 for interrupts.
- Class priority: any exception > `ret` > interrupt.
- IDLE, event seen:
  - Latch kind (exception/interrupt/ret), cause, `epc`, `badaddr`.
  - If `pipe_clear`=1 in the same cycle, go to REDIRECT; otherwise go to WAIT_CLEAR.
- WAIT_CLEAR:
  - Ignore new events.
  - Latched values stay frozen, even if the interrupt line drops.
  - Leave for REDIRECT on the first cycle with `pipe_clear`=1.
- REDIRECT (exactly 1 cycle), then IDLE:
  - `insert_pc`=1.
  - Trap: `mcause_wen`/`mepc_wen`/`mtval_wen`=1 and `mstatus_push`=1. `mtval_val`=badaddr for fault/misaligned codes 0,1,4,5,6,7; 0 otherwise.
  - `ret`: `mstatus_pop`=1, no CSR write strobes; `priv_pc`=`mepc_r`.
- Trap target, with base = {mtvec[31:2],2'b00}:
  - `mtvec[1:0]`==1 and interrupt: `priv_pc` = base + (cause[4:0]<<2), 32-bit wrap.
  - Otherwise: `priv_pc` = base.
- `intr` = 1 when a qualified interrupt is pending in IDLE with no exception/ret, or when the latched kind is interrupt in WAIT_CLEAR/REDIRECT.

## Timing
- Reset values: state IDLE; every output 0, including `priv_pc` and all `*_val`; latches cleared.
- Latency: event at cycle N with `pipe_clear`=1 gives `insert_pc` at N+1. If the drain completes at cycle M, `insert_pc` is at M+1.
- All outputs are registered-state decodes. `insert_pc` and the strobes never exceed 1 cycle per trap.
- In REDIRECT, new events are ignored. IDLE resamples them the following cycle, so back-to-back traps are separated by at least one IDLE cycle.
- `RST` asserted in any state: immediate return to IDLE, outputs 0, pending trap discarded. No strobe is emitted on release.
- Simultaneous exception and interrupt: the exception is taken. The interrupt stays pending and is retaken later if still asserted and enabled.

## Structure
- `machine_mode_types_1_12_pkg` holds the cause-code constants (`ex_cause_t`, `int_cause_t`), a new `trap_state_t` enum, and `TVEC_MODE_VECTORED`=2'b01.
- Priority encoding goes in one combinational sub-module, `trap_priority_enc`: flags in, {valid, kind, cause} out.
- The top level holds the FSM and the latches.

## Test plan
- `illegal_insn`=1 with `pipe_clear`=1, `epc`=0x100, mtvec=0x8000_0000 -> next cycle `insert_pc`=1, `priv_pc`=0x8000_0000, mcause=2, mepc=0x100, mtval=0, `mstatus_push`=1.
- `mal_l` and `fault_insn` asserted together, `badaddr`=0x203 -> mcause=1; `pipe_clear` held 0 for 3 cycles keeps the FSM in WAIT_CLEAR with no strobes; `insert_pc` occurs the cycle after `pipe_clear` rises.
- `ext_int`=1, meie=1, mstatus_mie=1, mtvec=0x400 | 1 -> `intr`=1 immediately; after `pipe_clear`, `priv_pc`=0x42C, mcause=0x8000_000B.
- `timer_int`=1 with mtie=0 -> no `intr`, stays IDLE. `timer_int` plus `env` together with mtie=1 -> mcause=11 (exception wins), bit31=0.
- `ret`=1, `mepc_r`=0x1234 -> `priv_pc`=0x1234, `mstatus_pop`=1, no CSR write strobes.
- `RST` pulsed while in WAIT_CLEAR -> all outputs 0, and no `insert_pc` after release even with `pipe_clear`=1.

Source files
------------

// File: rtl/machine_mode_types_1_12_pkg.sv
// Machine-mode trap constants: cause codes, trap FSM states, trap kinds and mtvec mode.
package machine_mode_types_1_12_pkg;

    localparam int NUM_EXTENSIONS = 4;
    localparam logic [1:0] TVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [4:0] {
        EX_MAL_INSN     = 5'd0,
        EX_FAULT_INSN   = 5'd1,
        EX_ILLEGAL_INSN = 5'd2,
        EX_BREAKPOINT   = 5'd3,
        EX_MAL_L        = 5'd4,
        EX_FAULT_L      = 5'd5,
        EX_MAL_S        = 5'd6,
        EX_FAULT_S      = 5'd7,
        EX_ECALL_M      = 5'd11
    } ex_cause_t;

    typedef enum logic [4:0] {
        INT_MSOFT  = 5'd3,
        INT_MTIMER = 5'd7,
        INT_MEXT   = 5'd11
    } int_cause_t;

    typedef enum logic [1:0] {
        TS_IDLE,
        TS_WAIT_CLEAR,
        TS_REDIRECT
    } trap_state_t;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_EXC,
        KIND_INT,
        KIND_RET
    } trap_kind_t;

    // Misaligned/fault codes (0,1,4,5,6,7) report the offending address in mtval.
    function automatic logic cause_has_tval(input logic [30:0] code);
        return (code < 31'd8) && (code != 31'(EX_ILLEGAL_INSN)) && (code != 31'(EX_BREAKPOINT));
    endfunction

endpackage

// File: rtl/trap_priority_enc.sv
// Combinational trap picker: exception > ret > qualified interrupt, fixed order inside each class.
module trap_priority_enc
    import machine_mode_types_1_12_pkg::*;
#(
    parameter int RMGMT_CAUSE_BASE = 24,
    parameter int EXT_W            = 2
) (
    input  logic             i_fault_insn,
    input  logic             i_mal_insn,
    input  logic             i_illegal_insn,
    input  logic             i_fault_l,
    input  logic             i_mal_l,
    input  logic             i_fault_s,
    input  logic             i_mal_s,
    input  logic             i_breakpoint,
    input  logic             i_env,
    input  logic             i_ret,
    input  logic             i_ex_rmgmt,
    input  logic [EXT_W-1:0] i_ex_rmgmt_cause,
    input  logic             i_timer_int,
    input  logic             i_soft_int,
    input  logic             i_ext_int,
    input  logic [2:0]       i_mie_bits,
    input  logic             i_mstatus_mie,
    output logic             o_vld,
    output trap_kind_t       o_kind,
    output logic [30:0]      o_cause
);

    logic w_ext_q;
    logic w_soft_q;
    logic w_timer_q;

    assign w_ext_q   = i_ext_int   & i_mie_bits[2] & i_mstatus_mie;
    assign w_soft_q  = i_soft_int  & i_mie_bits[1] & i_mstatus_mie;
    assign w_timer_q = i_timer_int & i_mie_bits[0] & i_mstatus_mie;

    always_comb begin
        o_vld   = 1'b1;
        o_kind  = KIND_EXC;
        o_cause = '0;
        if      (i_fault_insn)   o_cause = 31'(EX_FAULT_INSN);
        else if (i_mal_insn)     o_cause = 31'(EX_MAL_INSN);
        else if (i_illegal_insn) o_cause = 31'(EX_ILLEGAL_INSN);
        else if (i_breakpoint)   o_cause = 31'(EX_BREAKPOINT);
        else if (i_env)          o_cause = 31'(EX_ECALL_M);
        else if (i_mal_s)        o_cause = 31'(EX_MAL_S);
        else if (i_mal_l)        o_cause = 31'(EX_MAL_L);
        else if (i_fault_s)      o_cause = 31'(EX_FAULT_S);
        else if (i_fault_l)      o_cause = 31'(EX_FAULT_L);
        else if (i_ex_rmgmt)     o_cause = 31'(RMGMT_CAUSE_BASE) + 31'(i_ex_rmgmt_cause);
        else if (i_ret)          o_kind  = KIND_RET;
        else if (w_ext_q) begin
            o_kind  = KIND_INT;
            o_cause = 31'(INT_MEXT);
        end else if (w_soft_q) begin
            o_kind  = KIND_INT;
            o_cause = 31'(INT_MSOFT);
        end else if (w_timer_q) begin
            o_kind  = KIND_INT;
            o_cause = 31'(INT_MTIMER);
        end else begin
            o_vld  = 1'b0;
            o_kind = KIND_NONE;
        end
    end

endmodule

// File: rtl/priv_trap_ctrl.sv
// Trap sequencer: latch the winning trap, wait for the pipeline to drain, then issue a
// one-cycle redirect plus CSR update strobes. Outputs are decodes of registered state.
module priv_trap_ctrl
    import machine_mode_types_1_12_pkg::*;
#(
    parameter int NUM_EXT          = NUM_EXTENSIONS,
    parameter int RMGMT_CAUSE_BASE = 24,
    localparam int EXT_W           = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             fault_insn,
    input  logic             mal_insn,
    input  logic             illegal_insn,
    input  logic             fault_l,
    input  logic             mal_l,
    input  logic             fault_s,
    input  logic             mal_s,
    input  logic             breakpoint,
    input  logic             env,
    input  logic             ret,
    input  logic             ex_rmgmt,
    input  logic [EXT_W-1:0] ex_rmgmt_cause,
    input  logic [31:0]      epc,
    input  logic [31:0]      badaddr,
    input  logic             pipe_clear,
    input  logic             timer_int,
    input  logic             soft_int,
    input  logic             ext_int,
    input  logic [2:0]       mie_bits,
    input  logic             mstatus_mie,
    input  logic [31:0]      mtvec,
    input  logic [31:0]      mepc_r,
    output logic [31:0]      priv_pc,
    output logic             insert_pc,
    output logic             intr,
    output logic             mcause_wen,
    output logic             mepc_wen,
    output logic             mtval_wen,
    output logic [31:0]      mcause_val,
    output logic [31:0]      mepc_val,
    output logic [31:0]      mtval_val,
    output logic             mstatus_push,
    output logic             mstatus_pop
);

    trap_state_t r_state;
    trap_state_t w_state_nxt;
    trap_kind_t  r_kind;
    logic [30:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_badaddr;

    logic        w_vld;
    trap_kind_t  w_kind;
    logic [30:0] w_cause;
    logic        w_latch;
    logic [31:0] w_base;
    logic [31:0] w_vec_pc;

    trap_priority_enc #(
        .RMGMT_CAUSE_BASE (RMGMT_CAUSE_BASE),
        .EXT_W            (EXT_W)
    ) u_enc (
        .i_fault_insn     (fault_insn),
        .i_mal_insn       (mal_insn),
        .i_illegal_insn   (illegal_insn),
        .i_fault_l        (fault_l),
        .i_mal_l          (mal_l),
        .i_fault_s        (fault_s),
        .i_mal_s          (mal_s),
        .i_breakpoint     (breakpoint),
        .i_env            (env),
        .i_ret            (ret),
        .i_ex_rmgmt       (ex_rmgmt),
        .i_ex_rmgmt_cause (ex_rmgmt_cause),
        .i_timer_int      (timer_int),
        .i_soft_int       (soft_int),
        .i_ext_int        (ext_int),
        .i_mie_bits       (mie_bits),
        .i_mstatus_mie    (mstatus_mie),
        .o_vld            (w_vld),
        .o_kind           (w_kind),
        .o_cause          (w_cause)
    );

    assign w_base   = {mtvec[31:2], 2'b00};
    assign w_vec_pc = w_base + {25'd0, r_cause[4:0], 2'b00};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= TS_IDLE;
            r_kind    <= KIND_NONE;
            r_cause   <= '0;
            r_epc     <= '0;
            r_badaddr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_kind    <= w_kind;
                r_cause   <= w_cause;
                r_epc     <= epc;
                r_badaddr <= badaddr;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        priv_pc      = '0;
        insert_pc    = 1'b0;
        intr         = 1'b0;
        mcause_wen   = 1'b0;
        mepc_wen     = 1'b0;
        mtval_wen    = 1'b0;
        mcause_val   = '0;
        mepc_val     = '0;
        mtval_val    = '0;
        mstatus_push = 1'b0;
        mstatus_pop  = 1'b0;
        case (r_state)
            TS_IDLE: begin
                intr = w_vld && (w_kind == KIND_INT);
                if (w_vld) begin
                    w_latch     = 1'b1;
                    w_state_nxt = pipe_clear ? TS_REDIRECT : TS_WAIT_CLEAR;
                end
            end
            TS_WAIT_CLEAR: begin
                intr = (r_kind == KIND_INT);
                if (pipe_clear) w_state_nxt = TS_REDIRECT;
            end
            TS_REDIRECT: begin
                w_state_nxt = TS_IDLE;
                insert_pc   = 1'b1;
                intr        = (r_kind == KIND_INT);
                if (r_kind == KIND_RET) begin
                    priv_pc     = mepc_r;
                    mstatus_pop = 1'b1;
                end else begin
                    // Only interrupts use the vectored table; exceptions always go to base.
                    priv_pc      = (r_kind == KIND_INT && mtvec[1:0] == TVEC_MODE_VECTORED)
                                   ? w_vec_pc : w_base;
                    mcause_wen   = 1'b1;
                    mepc_wen     = 1'b1;
                    mtval_wen    = 1'b1;
                    mstatus_push = 1'b1;
                    mcause_val   = {r_kind == KIND_INT, r_cause};
                    mepc_val     = r_epc;
                    mtval_val    = (r_kind == KIND_EXC && cause_has_tval(r_cause)) ? r_badaddr : 32'd0;
                end
            end
            default: w_state_nxt = TS_IDLE;
        endcase
    end

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Directed bench for priv_trap_ctrl: stimulus pushes expected redirects, a negedge monitor pops and compares.
module tb_priv_trap_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
    logic        breakpoint, env, ret, ex_rmgmt;
    logic [1:0]  ex_rmgmt_cause;
    logic [31:0] epc, badaddr;
    logic        pipe_clear, timer_int, soft_int, ext_int;
    logic [2:0]  mie_bits;
    logic        mstatus_mie;
    logic [31:0] mtvec, mepc_r;
    logic [31:0] priv_pc;
    logic        insert_pc, intr, mcause_wen, mepc_wen, mtval_wen;
    logic [31:0] mcause_val, mepc_val, mtval_val;
    logic        mstatus_push, mstatus_pop;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        wen;
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic        push;
        logic        pop;
    } exp_t;

    exp_t sb_q[$];

    priv_trap_ctrl dut (
        .CLK            (CLK),
        .RST            (RST),
        .fault_insn     (fault_insn),
        .mal_insn       (mal_insn),
        .illegal_insn   (illegal_insn),
        .fault_l        (fault_l),
        .mal_l          (mal_l),
        .fault_s        (fault_s),
        .mal_s          (mal_s),
        .breakpoint     (breakpoint),
        .env            (env),
        .ret            (ret),
        .ex_rmgmt       (ex_rmgmt),
        .ex_rmgmt_cause (ex_rmgmt_cause),
        .epc            (epc),
        .badaddr        (badaddr),
        .pipe_clear     (pipe_clear),
        .timer_int      (timer_int),
        .soft_int       (soft_int),
        .ext_int        (ext_int),
        .mie_bits       (mie_bits),
        .mstatus_mie    (mstatus_mie),
        .mtvec          (mtvec),
        .mepc_r         (mepc_r),
        .priv_pc        (priv_pc),
        .insert_pc      (insert_pc),
        .intr           (intr),
        .mcause_wen     (mcause_wen),
        .mepc_wen       (mepc_wen),
        .mtval_wen      (mtval_wen),
        .mcause_val     (mcause_val),
        .mepc_val       (mepc_val),
        .mtval_val      (mtval_val),
        .mstatus_push   (mstatus_push),
        .mstatus_pop    (mstatus_pop)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic wen, input logic [31:0] mc,
                            input logic [31:0] me, input logic [31:0] mt,
                            input logic ps, input logic pp);
        exp_t e;
        e.pc = pc; e.wen = wen; e.mcause = mc; e.mepc = me; e.mtval = mt; e.push = ps; e.pop = pp;
        sb_q.push_back(e);
    endtask

    // Monitor: every redirect cycle must match the next queued expectation.
    always @(negedge CLK) begin
        if (insert_pc) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_redirect: got insert_pc=1 priv_pc=%h expected no redirect", priv_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("mon_priv_pc", priv_pc, e.pc);
                chk("mon_mcause_wen", 32'(mcause_wen), 32'(e.wen));
                chk("mon_mepc_wen", 32'(mepc_wen), 32'(e.wen));
                chk("mon_mtval_wen", 32'(mtval_wen), 32'(e.wen));
                chk("mon_push", 32'(mstatus_push), 32'(e.push));
                chk("mon_pop", 32'(mstatus_pop), 32'(e.pop));
                if (e.wen) begin
                    chk("mon_mcause_val", mcause_val, e.mcause);
                    chk("mon_mepc_val", mepc_val, e.mepc);
                    chk("mon_mtval_val", mtval_val, e.mtval);
                end
            end
        end
    end

    initial begin
        RST = 1'b1;
        {fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s} = '0;
        {breakpoint, env, ret, ex_rmgmt} = '0;
        ex_rmgmt_cause = '0;
        epc = '0; badaddr = '0; pipe_clear = 1'b0;
        {timer_int, soft_int, ext_int} = '0;
        mie_bits = '0; mstatus_mie = 1'b0;
        mtvec = '0; mepc_r = '0;
        tick();
        tick();
        chk("rst_insert_pc", 32'(insert_pc), 0);
        chk("rst_intr", 32'(intr), 0);
        chk("rst_priv_pc", priv_pc, 0);
        chk("rst_wens", {29'd0, mcause_wen, mepc_wen, mtval_wen}, 0);
        chk("rst_mstatus", {30'd0, mstatus_push, mstatus_pop}, 0);
        chk("rst_vals", mcause_val | mepc_val | mtval_val, 0);
        RST = 1'b0;
        tick();

        // Illegal instruction with the pipe already clear: redirect next cycle.
        illegal_insn = 1'b1; pipe_clear = 1'b1; epc = 32'h100; badaddr = 32'hDEAD; mtvec = 32'h8000_0000;
        push_exp(32'h8000_0000, 1'b1, 32'd2, 32'h100, 32'd0, 1'b1, 1'b0);
        tick();
        chk("t1_latency", 32'(insert_pc), 1);
        illegal_insn = 1'b0;
        tick();
        chk("t1_one_cycle", 32'(insert_pc), 0);

        // fault_insn beats mal_l; drain stalls three cycles.
        fault_insn = 1'b1; mal_l = 1'b1; pipe_clear = 1'b0; epc = 32'h200; badaddr = 32'h203;
        mtvec = 32'h8000_0001;
        tick();
        fault_insn = 1'b0; mal_l = 1'b0; badaddr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_wait_no_insert", 32'(insert_pc), 0);
            chk("t2_wait_no_wen", 32'(mcause_wen), 0);
            tick();
        end
        pipe_clear = 1'b1;
        push_exp(32'h8000_0000, 1'b1, 32'd1, 32'h200, 32'h203, 1'b1, 1'b0);
        tick();
        chk("t2_insert_after_clear", 32'(insert_pc), 1);
        tick();

        // External interrupt, vectored mtvec; line drops during the drain.
        ext_int = 1'b1; mie_bits = 3'b100; mstatus_mie = 1'b1; mtvec = 32'h401; pipe_clear = 1'b0;
        epc = 32'h500;
        #1;
        chk("t3_intr_immediate", 32'(intr), 1);
        tick();
        ext_int = 1'b0; epc = 32'h0;
        #1;
        chk("t3_intr_held", 32'(intr), 1);
        pipe_clear = 1'b1;
        push_exp(32'h42C, 1'b1, 32'h8000_000B, 32'h500, 32'd0, 1'b1, 1'b0);
        tick();
        chk("t3_insert", 32'(insert_pc), 1);
        tick();

        // Disabled timer is ignored; env with enabled timer takes env, then timer.
        timer_int = 1'b1; mie_bits = 3'b000; pipe_clear = 1'b1; epc = 32'h300; badaddr = 32'h55;
        #1;
        chk("t4_masked_intr", 32'(intr), 0);
        tick();
        chk("t4_masked_idle", 32'(insert_pc), 0);
        mie_bits = 3'b001; env = 1'b1;
        push_exp(32'h400, 1'b1, 32'd11, 32'h300, 32'd0, 1'b1, 1'b0);
        push_exp(32'h41C, 1'b1, 32'h8000_0007, 32'h300, 32'd0, 1'b1, 1'b0);
        #1;
        chk("t4_exc_hides_intr", 32'(intr), 0);
        tick();
        env = 1'b0;
        chk("t4_env_insert", 32'(insert_pc), 1);
        tick();
        chk("t4_idle_gap", 32'(insert_pc), 0);
        chk("t4_timer_pending", 32'(intr), 1);
        tick();
        chk("t4_timer_insert", 32'(insert_pc), 1);
        timer_int = 1'b0;
        tick();

        // RISC-MGMT exception index 2 -> cause 26.
        ex_rmgmt = 1'b1; ex_rmgmt_cause = 2'd2; epc = 32'h600; badaddr = 32'h77;
        push_exp(32'h400, 1'b1, 32'd26, 32'h600, 32'd0, 1'b1, 1'b0);
        tick();
        ex_rmgmt = 1'b0;
        tick();

        // mret.
        ret = 1'b1; mepc_r = 32'h1234;
        push_exp(32'h1234, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        ret = 1'b0;
        tick();

        // Reset during WAIT_CLEAR discards the pending trap.
        illegal_insn = 1'b1; pipe_clear = 1'b0;
        tick();
        illegal_insn = 1'b0;
        RST = 1'b1;
        #1;
        chk("t6_rst_insert", 32'(insert_pc), 0);
        chk("t6_rst_priv_pc", priv_pc, 0);
        chk("t6_rst_wen", 32'(mcause_wen), 0);
        tick();
        RST = 1'b0; pipe_clear = 1'b1;
        tick();
        chk("t6_no_insert_1", 32'(insert_pc), 0);
        tick();
        chk("t6_no_insert_2", 32'(insert_pc), 0);
        tick();

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
